// File: rtl/sar_adc.sv
// -----------------------------------------------------------------------------
// sar_adc -- behavioural successive-approximation ADC
//
// This block is the reverse path of the resistor-string DAC. It samples a
// normalised real analog level (full scale 0.0..1.0) when a conversion is
// accepted. It then resolves that level MSB-first into a WIDTH-bit code, one
// bit per clock.
//
// Parameters
//   WIDTH   output code width; a conversion takes WIDTH resolve cycles
//   OFFSET  comparator input offset in full-scale units, added to the held sample
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset
//   ana    in   real   analog input, nominal 0.0 <= ana < 1.0
//   start  in   1      conversion request, sampled on the rising edge of clk
//   busy   out  1      high while a conversion is in progress
//   done   out  1      one-cycle pulse: dig holds a new result
//   dig    out  WIDTH  last conversion result, held until the next done
// -----------------------------------------------------------------------------
module sar_adc #(
    parameter int  WIDTH  = 8,
    parameter real OFFSET = 0.0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  real              ana,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dig
);

    localparam real             SCALE = 2.0 ** WIDTH;
    localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t           state;
    state_t           state_next;
    real              hold;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] result_next;

    // Comparator: is the offset-corrected sample at or above the trial level?
    // The trial level is an exact binary fraction, so the compare is exact
    // for WIDTH <= 52. Over-range and under-range saturate naturally. Every
    // trial is kept above full scale, and every trial is rejected below zero.
    function automatic logic level_ge(input real level, input logic [WIDTH-1:0] code);
        return level >= (real'(code) / SCALE);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the trial decision for the bit being resolved this cycle.
    // The one-hot trial register doubles as the bit index; trial[0] marks the
    // last resolve cycle.
    always_comb begin
        state_next  = state;
        cand        = result | trial;
        result_next = result;
        if (state == IDLE) begin
            if (start) begin
                state_next = CONVERT;
            end
        end else begin
            if (level_ge(hold + OFFSET, cand)) begin
                result_next = cand;
            end
            if (trial[0]) begin
                state_next = IDLE;
            end
        end
    end

    assign busy = (state == CONVERT);

    // Sample / resolve / publish
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold   <= 0.0;
            trial  <= '0;
            result <= '0;
            dig    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    hold   <= ana;
                    trial  <= MSB;
                    result <= '0;
                end
            end else begin
                result <= result_next;
                trial  <= trial >> 1;
                // dig is only ever written with a fully resolved code.
                if (trial[0]) begin
                    dig  <= result_next;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
